// File: rtl/rf_wport_if.sv
// rf_wport_if
//   Bundle between the two writeback requesters, the write-port arbiter and
//   the register file.
//   Requester A (ALU/result path):        a_valid, a_addr, a_data -> ; <- a_ready
//   Requester B (load/multi-cycle path):  b_valid, b_addr, b_data -> ; <- b_ready
//   Register-file side (all registered):  rf_we, rf_waddr, rf_wdata, wsel
//   Status:                               busy (either buffer holds a write)
//   master: the requester/register-file side; slave: the arbiter.
interface rf_wport_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          wsel;
  logic          busy;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  rf_we, rf_waddr, rf_wdata, wsel, busy
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output rf_we, rf_waddr, rf_wdata, wsel, busy
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single register-file write port between requester A
//   (ALU/result) and requester B (load/multi-cycle). Each requester has a
//   one-entry buffer; buffered writes are issued round-robin onto registered
//   rf_we/rf_waddr/rf_wdata, with wsel steering the datapath address mux
//   (0 = A path, 1 = B path).
// Ports:
//   clk    - system clock, all state on the rising edge
//   rst_n  - synchronous active-low reset, drops all pending writes
//   wp     - rf_wport_if slave modport (handshakes, write port, busy)
module rf_wport_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  rf_wport_if.slave   wp
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  // Requester buffers
  logic          full_a_q, full_a_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [DW-1:0] data_a_q, data_a_d;
  logic          full_b_q, full_b_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [DW-1:0] data_b_q, data_b_d;

  // Round-robin pointer: who was granted most recently
  req_e          last_q, last_d;

  // Registered write port
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          wsel_q, wsel_d;

  logic          same_addr;
  logic          grant_a, grant_b;
  logic          ready_a, ready_b;
  logic          acc_a, acc_b;

  // Grants look only at registered buffer state so that ready never depends
  // on valid. On a same-address collision A always goes first, so B's value
  // is the one left in the register file.
  always_comb begin
    same_addr = (addr_a_q == addr_b_q);
    grant_a   = full_a_q & (~full_b_q | same_addr | (last_q == REQ_B));
    grant_b   = full_b_q & ~grant_a;
    ready_a   = ~full_a_q | grant_a;
    ready_b   = ~full_b_q | grant_b;
    acc_a     = wp.a_valid & ready_a;
    acc_b     = wp.b_valid & ready_b;
  end

  // Buffer next state: an accept refills the slot even while it drains.
  always_comb begin
    full_a_d = full_a_q;
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    full_b_d = full_b_q;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;

    if (grant_a) full_a_d = 1'b0;
    if (acc_a) begin
      full_a_d = 1'b1;
      addr_a_d = wp.a_addr;
      data_a_d = wp.a_data;
    end

    if (grant_b) full_b_d = 1'b0;
    if (acc_b) begin
      full_b_d = 1'b1;
      addr_b_d = wp.b_addr;
      data_b_d = wp.b_data;
    end
  end

  // Issue: a write to register 0 uses its slot but never raises rf_we.
  always_comb begin
    last_d     = last_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wsel_d     = wsel_q;

    if (grant_a) begin
      last_d     = REQ_A;
      rf_we_d    = (addr_a_q != '0);
      rf_waddr_d = addr_a_q;
      rf_wdata_d = data_a_q;
      wsel_d     = 1'b0;
    end else if (grant_b) begin
      last_d     = REQ_B;
      rf_we_d    = (addr_b_q != '0);
      rf_waddr_d = addr_b_q;
      rf_wdata_d = data_b_q;
      wsel_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_a_q   <= 1'b0;
      addr_a_q   <= '0;
      data_a_q   <= '0;
      full_b_q   <= 1'b0;
      addr_b_q   <= '0;
      data_b_q   <= '0;
      last_q     <= REQ_B;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wsel_q     <= 1'b0;
    end else begin
      full_a_q   <= full_a_d;
      addr_a_q   <= addr_a_d;
      data_a_q   <= data_a_d;
      full_b_q   <= full_b_d;
      addr_b_q   <= addr_b_d;
      data_b_q   <= data_b_d;
      last_q     <= last_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wsel_q     <= wsel_d;
    end
  end

  assign wp.a_ready  = ready_a;
  assign wp.b_ready  = ready_b;
  assign wp.rf_we    = rf_we_q;
  assign wp.rf_waddr = rf_waddr_q;
  assign wp.rf_wdata = rf_wdata_q;
  assign wp.wsel     = wsel_q;
  assign wp.busy     = full_a_q | full_b_q;

endmodule
